// File: rtl/f1_sequencer.sv
// LED fill sequencer: lights ledr one bit per STEP_TICKS ticks, holds all-on, then pulses time_out.
// Define RANDOM_DELAY_EN to take the hold length from a free-running 7-bit LFSR instead of HOLD_TICKS.
module f1_sequencer #(
    parameter int STEP_TICKS = 500,
    parameter int HOLD_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    output logic [9:0] ledr,
    output logic       time_out,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for start, LEDs dark
    // LIGHT | filling ledr one bit every STEP_TICKS ticks
    // HOLD  | all LEDs lit for hold_len ticks
    // OFF   | single cycle, LEDs dark, time_out pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2,
        OFF   = 2'd3
    } state_t;

    localparam logic [9:0] STEP_LAST = 10'(STEP_TICKS - 1);

    state_t     state;
    logic [9:0] count;
    logic [9:0] hold_len;
    logic       light_done;

    assign light_done = (state == LIGHT) && tick && (count == STEP_LAST) && (ledr == 10'h3FF);

`ifdef RANDOM_DELAY_EN
    logic [6:0] lfsr;
    logic [6:0] hold_q;

    // x^7 + x^6 + 1; seeded non-zero, so the register can never reach 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= 7'h01;
            hold_q <= 7'h01;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            if (light_done) begin
                hold_q <= lfsr;
            end
        end
    end

    assign hold_len = {3'b000, hold_q};
`else
    assign hold_len = 10'(HOLD_TICKS);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            ledr     <= '0;
            time_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            time_out <= 1'b0;
            case (state)
                IDLE: begin
                    ledr <= '0;
                    busy <= 1'b0;
                    // a tick arriving with the accepting start is deliberately not counted
                    if (start) begin
                        state <= LIGHT;
                        count <= '0;
                        ledr  <= 10'h001;
                        busy  <= 1'b1;
                    end
                end
                LIGHT: begin
                    if (tick) begin
                        if (count == STEP_LAST) begin
                            count <= '0;
                            if (light_done) begin
                                state <= HOLD;
                            end else begin
                                ledr <= {ledr[8:0], 1'b1};
                            end
                        end else begin
                            count <= count + 10'd1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (count == hold_len - 10'd1) begin
                            state    <= OFF;
                            count    <= '0;
                            ledr     <= '0;
                            time_out <= 1'b1;
                        end else begin
                            count <= count + 10'd1;
                        end
                    end
                end
                OFF: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
